// File: rtl/dose_confirm_monitor_pkg.sv
// Shared types and constants for the dose confirmation monitor.
// Other blocks on the dispense path use the same slot encoding.
package dose_confirm_monitor_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WAIT_DROP = 2'd1,
      MISSED    = 2'd2
   } state_t;

   localparam logic [1:0] SLOT_OVR       = 2'd0;
   localparam logic [1:0] SLOT_MORNING   = 2'd1;
   localparam logic [1:0] SLOT_AFTERNOON = 2'd2;
   localparam logic [1:0] SLOT_EVENING   = 2'd3;

endpackage

// File: rtl/dose_confirm_monitor_sensor_debounce.sv
// Two-flop synchroniser plus level debouncer for a raw GPIO input.
// The stable level changes only after DEBOUNCE_CYCLES consecutive mismatching samples.
module sensor_debounce #(
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic clock,
   input  logic reset,
   input  logic din,
   output logic level,
   output logic rise
);

   localparam int CW = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);

   logic [1:0]    sync;
   logic [CW-1:0] cnt;

   always_ff @(posedge clock) begin
      if (reset) begin
         sync  <= '0;
         cnt   <= '0;
         level <= 1'b0;
         rise  <= 1'b0;
      end else begin
         sync <= {sync[0], din};
         rise <= 1'b0;
         if (sync[1] != level) begin
            // final mismatching sample: accept the new level
            if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
               level <= sync[1];
               rise  <= sync[1];
               cnt   <= '0;
            end else begin
               cnt <= cnt + CW'(1);
            end
         end else begin
            cnt <= '0;
         end
      end
   end

endmodule

// File: rtl/dose_confirm_monitor.sv
// Confirms each dispensed dose drops within a timeout; counts taken/missed doses
// and latches a missed-dose alarm until the user presses KEY.
//
// state     | meaning
// IDLE      | no dose outstanding
// WAIT_DROP | actuator fired, waiting for the drop sensor or timeout
// MISSED    | timeout expired, alarm latched until KEY pressed
module dose_confirm_monitor
   import dose_confirm_monitor_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int TIMEOUT_S       = 5,
   parameter int CNT_W           = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             secondP,
   input  logic             dispense_fire,
   input  logic [1:0]       slot,
   input  logic             sensor_in,
   input  logic             key,
   output logic             dose_ok,
   output logic             dose_missed,
   output logic             alarm,
   output logic             stray,
   output logic             overrun,
   output logic             busy,
   output logic [1:0]       last_slot,
   output logic [CNT_W-1:0] taken_count,
   output logic [CNT_W-1:0] missed_count
);

   localparam int SEC_W = (TIMEOUT_S < 2) ? 1 : $clog2(TIMEOUT_S + 1);

   state_t             state, state_n;
   logic [1:0]         slot_cap, slot_cap_n;
   logic [SEC_W-1:0]   sec_cnt, sec_n;
   logic [CNT_W-1:0]   taken_n, missed_n;
   logic [1:0]         last_n;
   logic               alarm_n, ok_n, miss_n, stray_n, over_n;
   logic               drop_evt;
   logic               sensor_level;

   sensor_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_sensor (
      .clock(clock),
      .reset(reset),
      .din  (sensor_in),
      .level(sensor_level),
      .rise (drop_evt)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         state        <= IDLE;
         slot_cap     <= SLOT_OVR;
         sec_cnt      <= '0;
         dose_ok      <= 1'b0;
         dose_missed  <= 1'b0;
         alarm        <= 1'b0;
         stray        <= 1'b0;
         overrun      <= 1'b0;
         busy         <= 1'b0;
         last_slot    <= SLOT_OVR;
         taken_count  <= '0;
         missed_count <= '0;
      end else begin
         state        <= state_n;
         slot_cap     <= slot_cap_n;
         sec_cnt      <= sec_n;
         dose_ok      <= ok_n;
         dose_missed  <= miss_n;
         alarm        <= alarm_n;
         stray        <= stray_n;
         overrun      <= over_n;
         busy         <= (state_n == WAIT_DROP);
         last_slot    <= last_n;
         taken_count  <= taken_n;
         missed_count <= missed_n;
      end
   end

   always_comb begin
      state_n    = state;
      slot_cap_n = slot_cap;
      sec_n      = sec_cnt;
      taken_n    = taken_count;
      missed_n   = missed_count;
      last_n     = last_slot;
      alarm_n    = alarm;
      ok_n       = 1'b0;
      miss_n     = 1'b0;
      stray_n    = 1'b0;
      over_n     = 1'b0;

      unique case (state)
         IDLE: begin
            if (drop_evt) stray_n = 1'b1;
            if (dispense_fire) begin
               slot_cap_n = slot;
               sec_n      = '0;
               state_n    = WAIT_DROP;
            end
         end
         WAIT_DROP: begin
            if (dispense_fire) over_n = 1'b1;
            // a drop beats a coincident timeout tick
            if (drop_evt) begin
               ok_n    = 1'b1;
               taken_n = (&taken_count) ? taken_count : taken_count + CNT_W'(1);
               last_n  = slot_cap;
               state_n = IDLE;
            end else if (secondP) begin
               if (sec_cnt == SEC_W'(TIMEOUT_S - 1)) begin
                  miss_n   = 1'b1;
                  missed_n = (&missed_count) ? missed_count : missed_count + CNT_W'(1);
                  last_n   = slot_cap;
                  alarm_n  = 1'b1;
                  state_n  = MISSED;
               end else begin
                  sec_n = sec_cnt + SEC_W'(1);
               end
            end
         end
         MISSED: begin
            alarm_n = 1'b1;
            if (dispense_fire) over_n = 1'b1;
            if (drop_evt) stray_n = 1'b1;
            if (!key) begin
               alarm_n = 1'b0;
               state_n = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

endmodule
